// File: rtl/readout_diff_integrator.sv
//------------------------------------------------------------------------------
// Module  : readout_diff_integrator
// Purpose : Windowed signed integrator for readout difference samples with
//           valid/ready result handshake and one-bit state discrimination.
//           Optional macro ACC_SATURATE_EN selects clamping instead of wrap.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module readout_diff_integrator #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int LEN_WIDTH  = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [LEN_WIDTH-1:0]        window_len,
  input  logic                        in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic signed [ACC_WIDTH-1:0] out_acc,
  output logic                        out_state,
  output logic                        out_sat,
  output logic                        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [LEN_WIDTH-1:0]        cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0] sum_red;

`ifdef ACC_SATURATE_EN
  logic signed [ACC_WIDTH:0] sum_full;
  logic                      clamp;
  logic                      sat_q;

  assign sum_full = {acc_q[ACC_WIDTH-1], acc_q}
                  + {{(ACC_WIDTH+1-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};

  // The two top bits of the widened sum disagree exactly when the result leaves the ACC_WIDTH range.
  always_comb begin
    clamp   = sum_full[ACC_WIDTH] != sum_full[ACC_WIDTH-1];
    sum_red = sum_full[ACC_WIDTH-1:0];
    if (clamp) begin
      sum_red = sum_full[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      sat_q <= 1'b0;
    end else if (state_q == S_ACCUM && in_valid && clamp) begin
      sat_q <= 1'b1;
    end
  end

  assign out_sat = sat_q;
`else
  assign sum_red = acc_q + {{(ACC_WIDTH-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
  assign out_sat = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = window_len;
          acc_d   = '0;
          state_d = (window_len == '0) ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          acc_d = sum_red;
          cnt_d = cnt_q - LEN_WIDTH'(1);
          if (cnt_q == LEN_WIDTH'(1)) begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = (state_q == S_HOLD);
  assign busy      = (state_q != S_IDLE);
  assign out_acc   = acc_q;
  assign out_state = ~acc_q[ACC_WIDTH-1];

endmodule

`default_nettype wire
